// File: rtl/registro_universal_n_pkg.sv
//==============================================================================
// registro_pkg : operation codes, FSM states and the shared step function
//                of the universal shift register. Rev 1.0
//==============================================================================
`default_nettype none

package registro_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        SHL  = 3'd1,
        SHR  = 3'd2,
        LOAD = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5
    } modo_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } estado_t;

    function automatic logic es_desplazamiento(input logic [2:0] modo);
        return (modo == SHL) || (modo == SHR) || (modo == ROL) || (modo == ROR);
    endfunction

    // Operates on a MAX_W-wide container; w is the live width, upper bits are cleared.
    function automatic logic [MAX_W-1:0] siguiente(
        input logic [MAX_W-1:0] q,
        input logic [2:0]       modo,
        input logic             din_msb,
        input logic             din_lsb,
        input logic [MAX_W-1:0] d_par,
        input int unsigned      w
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] r;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        case (modo)
            SHL:     r = (q << 1) | MAX_W'(din_lsb);
            SHR:     r = (q >> 1) | (MAX_W'(din_msb) << (w - 1));
            ROL:     r = (q << 1) | ((q >> (w - 1)) & MAX_W'(1));
            ROR:     r = (q >> 1) | ((q & MAX_W'(1)) << (w - 1));
            LOAD:    r = d_par;
            default: r = q;
        endcase
        return r & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/registro_universal_n_if.sv
//==============================================================================
// registro_universal_n_if : control/data bundle of the universal shift register.
// Rev 1.0
//==============================================================================
`default_nettype none

interface registro_universal_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic [2:0]       modo;
    logic             en;
    logic             start;
    logic [CNT_W-1:0] cuenta;
    logic             din_msb;
    logic             din_lsb;
    logic [WIDTH-1:0] d_par;
    logic [WIDTH-1:0] q;
    logic             q_msb;
    logic             q_lsb;
    logic             busy;
    logic             done;

    modport master (
        output modo, en, start, cuenta, din_msb, din_lsb, d_par,
        input  q, q_msb, q_lsb, busy, done
    );

    modport slave (
        input  modo, en, start, cuenta, din_msb, din_lsb, d_par,
        output q, q_msb, q_lsb, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/registro_universal_n_nucleo.sv
//==============================================================================
// nucleo_desplazamiento : WIDTH-bit register with the step multiplexer.
// Rev 1.0
//==============================================================================
`default_nettype none

module nucleo_desplazamiento
    import registro_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             step_i,
    input  wire logic [2:0]       modo_i,
    input  wire logic             din_msb_i,
    input  wire logic             din_lsb_i,
    input  wire logic [WIDTH-1:0] d_par_i,
    output logic      [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [MAX_W-1:0] w_next;

    assign w_next = siguiente(MAX_W'(q_q), modo_i, din_msb_i, din_lsb_i,
                              MAX_W'(d_par_i), WIDTH);

    generate
        if (WIDTH < MAX_W) begin : g_pad
            logic w_unused_hi;
            assign w_unused_hi = ^w_next[MAX_W-1:WIDTH];
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (step_i) begin
            q_d = w_next[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

`default_nettype wire

// File: rtl/registro_universal_n.sv
//==============================================================================
// registro_universal_n : universal shift register with single-step and burst
//                        control (IDLE/RUN/FIN). Rev 1.0
//==============================================================================
`default_nettype none

module registro_universal_n
    import registro_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input wire logic              clk,
    input wire logic              rst,
    registro_universal_n_if.slave bus
);
    estado_t          state_q, state_d;
    logic [CNT_W-1:0] ctr_q, ctr_d;
    logic [2:0]       modo_q, modo_d;
    logic             step_en;
    logic [2:0]       step_modo;
    logic [CNT_W-1:0] w_n;
    logic [WIDTH-1:0] w_q;

    assign w_n = (bus.cuenta > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.cuenta;

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        modo_d    = modo_q;
        step_en   = 1'b0;
        step_modo = bus.modo;
        case (state_q)
            IDLE: begin
                // start takes priority over en and never steps on its own edge
                if (bus.start) begin
                    modo_d = bus.modo;
                    if ((w_n != '0) && es_desplazamiento(bus.modo)) begin
                        state_d = RUN;
                        ctr_d   = w_n;
                    end else begin
                        state_d = FIN;
                    end
                end else if (bus.en) begin
                    step_en = 1'b1;
                end
            end
            RUN: begin
                step_en   = 1'b1;
                step_modo = modo_q;
                ctr_d     = ctr_q - CNT_W'(1);
                if (ctr_q == CNT_W'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            modo_q  <= HOLD;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            modo_q  <= modo_d;
        end
    end

    nucleo_desplazamiento #(
        .WIDTH (WIDTH)
    ) u_nucleo (
        .clk       (clk),
        .rst       (rst),
        .step_i    (step_en),
        .modo_i    (step_modo),
        .din_msb_i (bus.din_msb),
        .din_lsb_i (bus.din_lsb),
        .d_par_i   (bus.d_par),
        .q_o       (w_q)
    );

    assign bus.q     = w_q;
    assign bus.q_msb = w_q[WIDTH-1];
    assign bus.q_lsb = w_q[0];
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == FIN);
endmodule

`default_nettype wire
